// File: rtl/entrada_i2s_pkg.sv
// Shared I2S definitions: default word width, synchronizer depth, receiver FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package entrada_i2s_pkg;

    // Audio word width per channel and synchronizer depth, shared with the I2S transmitter.
    localparam int DATA_W_DEF      = 24;
    localparam int SYNC_STAGES_DEF = 2;

    // ALIGN: waiting for the first left-slot boundary. RECV: collecting slots.
    typedef enum logic {
        ALIGN = 1'b0,
        RECV  = 1'b1
    } i2s_state_t;

    // Bits needed to count 0..w inclusive.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/entrada_i2s_if.sv
// I2S receive bundle: serial inputs from the external master plus the parallel sample outputs.
// Latency: n/a (wiring only).
// Backpressure: none; valid and frame_err are single-cycle strobes with no ready.
// Ports: sclk/lrck/sdin (serial in), l_data/r_data (samples), valid, frame_err (strobes).
interface entrada_i2s_if
    import entrada_i2s_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
);
    logic                     sclk;
    logic                     lrck;
    logic                     sdin;
    logic signed [DATA_W-1:0] l_data;
    logic signed [DATA_W-1:0] r_data;
    logic                     valid;
    logic                     frame_err;

    // The side driving the serial lines.
    modport master (
        output sclk, lrck, sdin,
        input  l_data, r_data, valid, frame_err
    );

    // The receiver.
    modport slave (
        input  sclk, lrck, sdin,
        output l_data, r_data, valid, frame_err
    );
endinterface

// File: rtl/entrada_i2s_sync_edge.sv
// Multi-bit synchronizer; bit 0 also gets a rising-edge detector, upper bits are only synchronized.
// Latency: STAGES clk from input to o_sync/o_rise.
// Backpressure: none.
// Ports: clk, reset (async active-low), i_d (async inputs), o_sync (upper bits synced), o_rise (bit 0 rise).
module entrada_i2s_sync_edge #(
    parameter int W      = 3,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] i_d,
    output logic [W-1:1] o_sync,
    output logic         o_rise
);
    logic [W-1:0] r_sync [STAGES];
    logic         r_prev;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < STAGES; i++) begin
                r_sync[i] <= '0;
            end
            r_prev <= 1'b0;
        end else begin
            r_sync[0] <= i_d;
            for (int i = 1; i < STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            r_prev <= r_sync[STAGES-1][0];
        end
    end

    // All bits travel through identical stages, so the upper bits are aligned with the edge strobe.
    assign o_sync = r_sync[STAGES-1][W-1:1];
    assign o_rise = r_sync[STAGES-1][0] & ~r_prev;

endmodule

// File: rtl/entrada_i2s.sv
// I2S slave receiver: oversamples sclk/lrck/sdin on clk, assembles left/right words, emits pairs.
// Latency: valid rises on the 2nd clk after the sclk-rise detect that closes the right slot.
// Backpressure: none; each pair is presented once with a one-clk valid strobe.
// Ports: clk, reset (async active-low), bus (slave modport: serial in, l_data/r_data/valid/frame_err out).
module entrada_i2s
    import entrada_i2s_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic         clk,
    input  logic         reset,
    entrada_i2s_if.slave bus
);
    localparam int               CNT_W    = cnt_width(DATA_W);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);

    logic [2:1] w_sync;
    logic       w_det;
    logic       w_lrck;
    logic       w_sdin;

    i2s_state_t               r_state;
    i2s_state_t               w_state_nxt;
    logic [CNT_W-1:0]         r_cnt;
    logic [CNT_W-1:0]         w_cnt_nxt;
    logic [CNT_W-1:0]         w_cnt_slot;
    logic [DATA_W-1:0]        r_shift;
    logic [DATA_W-1:0]        w_shift_nxt;
    logic [DATA_W-1:0]        w_shift_slot;
    logic [DATA_W-1:0]        r_hold;
    logic                     r_left_ok;
    logic                     r_lrck_prev;
    logic                     w_fin_left;
    logic                     w_fin_right;
    logic signed [DATA_W-1:0] r_l_data;
    logic signed [DATA_W-1:0] r_r_data;
    logic                     r_pair_done;
    logic                     r_valid;
    logic                     r_frame_err;

    // sclk on bit 0 gets the edge detector; lrck and sdin only ride through the same stages.
    entrada_i2s_sync_edge #(
        .W      (3),
        .STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk    (clk),
        .reset  (reset),
        .i_d    ({bus.sdin, bus.lrck, bus.sclk}),
        .o_sync (w_sync),
        .o_rise (w_det)
    );

    assign w_lrck = w_sync[1];
    assign w_sdin = w_sync[2];

    // Slot contents after this detect's bit is taken: bits past DATA_W (long slots) are dropped.
    assign w_shift_slot = (r_cnt < CNT_FULL) ? {r_shift[DATA_W-2:0], w_sdin} : r_shift;
    assign w_cnt_slot   = (r_cnt < CNT_FULL) ? r_cnt + CNT_W'(1) : r_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ALIGN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_shift_nxt = r_shift;
        w_fin_left  = 1'b0;
        w_fin_right = 1'b0;
        case (r_state)
            ALIGN: begin
                // The bit seen with the 1->0 lrck change is the tail of an unseen right slot.
                if (w_det && r_lrck_prev && !w_lrck) begin
                    w_state_nxt = RECV;
                    w_cnt_nxt   = '0;
                    w_shift_nxt = '0;
                end
            end
            RECV: begin
                if (w_det) begin
                    if (w_lrck != r_lrck_prev) begin
                        // One-bit delay: this bit is the LSB of the slot being closed.
                        w_fin_left  = w_lrck;
                        w_fin_right = !w_lrck;
                        w_cnt_nxt   = '0;
                        w_shift_nxt = '0;
                    end else begin
                        w_cnt_nxt   = w_cnt_slot;
                        w_shift_nxt = w_shift_slot;
                    end
                end
            end
            default: begin
                w_state_nxt = ALIGN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt       <= '0;
            r_shift     <= '0;
            r_hold      <= '0;
            r_left_ok   <= 1'b0;
            r_lrck_prev <= 1'b0;
            r_l_data    <= '0;
            r_r_data    <= '0;
            r_pair_done <= 1'b0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_cnt       <= w_cnt_nxt;
            r_shift     <= w_shift_nxt;
            r_pair_done <= 1'b0;
            r_frame_err <= 1'b0;
            // Data registers load first; valid follows one clk later so the pair is already stable.
            r_valid     <= r_pair_done;
            if (w_det) begin
                r_lrck_prev <= w_lrck;
            end
            if (w_fin_left) begin
                if (w_cnt_slot == CNT_FULL) begin
                    r_hold    <= w_shift_slot;
                    r_left_ok <= 1'b1;
                end else begin
                    r_left_ok   <= 1'b0;
                    r_frame_err <= 1'b1;
                end
            end
            if (w_fin_right) begin
                r_left_ok <= 1'b0;
                if (w_cnt_slot == CNT_FULL) begin
                    // A full right slot without a good left partner is dropped silently.
                    if (r_left_ok) begin
                        r_l_data    <= r_hold;
                        r_r_data    <= w_shift_slot;
                        r_pair_done <= 1'b1;
                    end
                end else begin
                    r_frame_err <= 1'b1;
                end
            end
        end
    end

    assign bus.l_data    = r_l_data;
    assign bus.r_data    = r_r_data;
    assign bus.valid     = r_valid;
    assign bus.frame_err = r_frame_err;

endmodule

// File: tb/tb_entrada_i2s.sv
module tb_entrada_i2s;
    localparam int DW = 24;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    entrada_i2s_if #(.DATA_W(DW)) i2s ();

    entrada_i2s #(
        .DATA_W      (DW),
        .SYNC_STAGES (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (i2s)
    );

    logic [DW-1:0] l_u;
    logic [DW-1:0] r_u;
    assign l_u = i2s.l_data;
    assign r_u = i2s.r_data;

    int n_checks   = 0;
    int n_errors   = 0;
    int seen_valid = 0;
    int seen_err   = 0;
    int exp_valid  = 0;
    int exp_err    = 0;

    // Reference model: what the receiver must report, derived from the slots the bench sent.
    logic [DW-1:0] exp_l[$];
    logic [DW-1:0] exp_r[$];
    logic [DW-1:0] last_l = '0;
    logic [DW-1:0] last_r = '0;
    logic [DW-1:0] mon_l;
    logic [DW-1:0] mon_r;
    logic pend       = 1'b0;
    logic prev_valid = 1'b0;
    logic prev_err   = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One sclk period (8 clk): data and lrck change with sclk falling, sampled on sclk rising.
    task automatic send_bit(input logic lr, input logic d);
        @(negedge clk);
        i2s.sclk = 1'b0;
        i2s.lrck = lr;
        i2s.sdin = d;
        repeat (4) @(negedge clk);
        i2s.sclk = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    // Slot bits are MSB-aligned in 'bits'; each period carries the previous bit (I2S one-bit delay).
    task automatic send_slot(input logic lr, input logic [31:0] bits, input int n);
        for (int k = 0; k < n; k++) begin
            send_bit(lr, pend);
            pend = bits[31-k];
        end
    endtask

    // Closes the final right slot by presenting its LSB under lrck=0.
    task automatic send_tail();
        send_bit(1'b0, pend);
    endtask

    task automatic send_frame(input logic [31:0] lb, input int ln, input logic [31:0] rb, input int rn);
        logic lok;
        lok = (ln >= DW);
        if (!lok) exp_err++;
        if (rn < DW) begin
            exp_err++;
        end else if (lok) begin
            exp_l.push_back(lb[31 -: DW]);
            exp_r.push_back(rb[31 -: DW]);
            last_l = lb[31 -: DW];
            last_r = rb[31 -: DW];
            exp_valid++;
        end
        send_slot(1'b0, lb, ln);
        send_slot(1'b1, rb, rn);
    endtask

    task automatic preamble();
        send_slot(1'b1, $urandom, $urandom_range(1, 20));
    endtask

    task automatic model_clear();
        exp_l.delete();
        exp_r.delete();
        last_l = '0;
        last_r = '0;
    endtask

    task automatic do_reset();
        reset    = 1'b0;
        i2s.sclk = 1'b0;
        i2s.lrck = 1'b0;
        i2s.sdin = 1'b0;
        model_clear();
        repeat (4) @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic end_checks(input string tag);
        repeat (40) @(negedge clk);
        check_eq({tag, "_pairs_outstanding"}, 64'(exp_l.size()), 64'd0);
        check_eq({tag, "_valid_count"}, 64'(seen_valid), 64'(exp_valid));
        check_eq({tag, "_frame_err_count"}, 64'(seen_err), 64'(exp_err));
        check_eq({tag, "_l_hold"}, 64'(l_u), 64'(last_l));
        check_eq({tag, "_r_hold"}, 64'(r_u), 64'(last_r));
    endtask

    function automatic int rand_len();
        int sel;
        sel = $urandom_range(0, 4);
        return 16 + 4 * sel;
    endfunction

    always @(negedge clk) begin
        if (reset === 1'b1) begin
            if (i2s.valid === 1'b1) begin
                seen_valid++;
                check_eq("valid_one_clk", 64'(prev_valid), 64'd0);
                check_eq("valid_err_exclusive", 64'(i2s.frame_err), 64'd0);
                check_eq("valid_expected", 64'(exp_l.size() > 0), 64'd1);
                if (exp_l.size() > 0) begin
                    mon_l = exp_l.pop_front();
                    mon_r = exp_r.pop_front();
                    check_eq("l_data", 64'(l_u), 64'(mon_l));
                    check_eq("r_data", 64'(r_u), 64'(mon_r));
                end
            end
            if (i2s.frame_err === 1'b1) begin
                seen_err++;
                check_eq("frame_err_one_clk", 64'(prev_err), 64'd0);
            end
            prev_valid = i2s.valid;
            prev_err   = i2s.frame_err;
        end else begin
            prev_valid = 1'b0;
            prev_err   = 1'b0;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] base;
        int            v0;
        int            ln;
        int            rn;

        reset    = 1'b0;
        i2s.sclk = 1'b0;
        i2s.lrck = 1'b0;
        i2s.sdin = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_l_data", 64'(l_u), 64'd0);
        check_eq("rst_r_data", 64'(r_u), 64'd0);
        check_eq("rst_valid", 64'(i2s.valid), 64'd0);
        check_eq("rst_frame_err", 64'(i2s.frame_err), 64'd0);
        reset = 1'b1;
        repeat (4) @(negedge clk);

        // Basic 24-bit frame, entering mid-right-slot.
        preamble();
        send_frame({24'h123456, 8'h00}, 24, {24'hABCDEF, 8'h00}, 24);
        send_tail();
        end_checks("basic");

        // 32-bit slots: padding after the 24 data bits is ignored.
        do_reset();
        preamble();
        send_frame({24'h800001, 8'hFF}, 32, {24'h7FFFFE, 8'h00}, 32);
        send_tail();
        end_checks("slot32");

        // Entry mid-left-slot: the following right slot alone must not yield a pair.
        do_reset();
        send_slot(1'b0, $urandom, $urandom_range(3, 20));
        send_slot(1'b1, $urandom, 24);
        send_frame($urandom, 24, $urandom, 24);
        send_tail();
        end_checks("midleft");

        // Short left slot: frame_err, no pair, previous outputs held.
        do_reset();
        preamble();
        send_frame($urandom, 24, $urandom, 24);
        send_frame($urandom, 16, $urandom, 24);
        send_tail();
        end_checks("short_left");

        // Reset in the middle of a left slot clears outputs at once; a fresh frame then works.
        do_reset();
        preamble();
        send_frame($urandom, 24, $urandom, 24);
        send_slot(1'b0, $urandom, 10);
        end_checks("pre_reset");
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_eq("async_rst_l_data", 64'(l_u), 64'd0);
        check_eq("async_rst_r_data", 64'(r_u), 64'd0);
        check_eq("async_rst_valid", 64'(i2s.valid), 64'd0);
        check_eq("async_rst_frame_err", 64'(i2s.frame_err), 64'd0);
        i2s.sclk = 1'b0;
        i2s.lrck = 1'b0;
        model_clear();
        repeat (4) @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        preamble();
        send_frame({24'h000F0F, 8'h00}, 24, {24'hF0F000, 8'h00}, 24);
        send_tail();
        end_checks("post_reset");

        // Ten back-to-back frames with incrementing samples and random 24/32-bit slots.
        do_reset();
        preamble();
        base = DW'($urandom);
        v0   = seen_valid;
        for (int i = 0; i < 10; i++) begin
            ln = ($urandom_range(0, 1) == 1) ? 32 : 24;
            rn = ($urandom_range(0, 1) == 1) ? 32 : 24;
            send_frame({base + DW'(i), 8'($urandom)}, ln, {base + DW'(i) + DW'(24'h000100), 8'($urandom)}, rn);
        end
        send_tail();
        end_checks("burst10");
        check_eq("burst10_valid_pulses", 64'(seen_valid - v0), 64'd10);

        // Random mix of full, long and short slots.
        do_reset();
        preamble();
        for (int i = 0; i < 12; i++) begin
            send_frame($urandom, rand_len(), $urandom, rand_len());
        end
        send_tail();
        end_checks("random_mix");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/entrada_i2s.md
ENTRADA_I2S -- requirements
Module: entrada_i2s

Interface
REQ-001 Parameter DATA_W, default 24: audio word width per channel, MSB-first, two's complement.
REQ-002 Parameter SYNC_STAGES, default 2: flip-flop depth of input synchronizers.
REQ-003 Port clk  input  1  system clock (16 MHz); the only clock.
REQ-004 Port reset  input  1  asynchronous, active-low reset.
REQ-005 Port sclk  input  1  I2S serial bit clock from external master; max frequency clk/4.
REQ-006 Port lrck  input  1  I2S word clock; 0 = left slot, 1 = right slot.
REQ-007 Port sdin  input  1  I2S serial audio data.
REQ-008 Port l_data  output  DATA_W  last complete left sample, signed.
REQ-009 Port r_data  output  DATA_W  last complete right sample, signed.
REQ-010 Port valid  output  1  one-clk pulse: new l_data/r_data pair updated.
REQ-011 Port frame_err  output  1  one-clk pulse: a slot was discarded as short.

Function
REQ-012 sclk, lrck, sdin SHALL each pass through SYNC_STAGES flops on clk before any use.
REQ-013 An sclk rising edge SHALL be detected as synchronized sclk = 1 with previous synchronized value = 0; all capture occurs only on that detect cycle.
REQ-014 On each detect, synchronized lrck and sdin SHALL be sampled together; lrck_prev holds lrck from the previous detect.
REQ-015 Format is standard I2S (one-bit delay): the sdin bit sampled at the first detect after an lrck change is the LSB of the previous slot; the next bit is the MSB of the new slot.
REQ-016 FSM states: ALIGN, RECV. After reset the FSM SHALL be in ALIGN and capture nothing until a detect sees lrck 1->0, then enter RECV with bit count 0.
REQ-017 In RECV, each detect SHALL shift sdin into the shift register if bit count < DATA_W, and increment count saturating at DATA_W.
REQ-018 Bits beyond DATA_W in a slot (e.g. 32-bit slots) SHALL be ignored; the first DATA_W bits after the MSB are kept.
REQ-019 On a detect where lrck != lrck_prev, the bit SHALL be shifted in first (per REQ-017), then the slot finalized, then count and shift register cleared for the new slot.
REQ-020 Finalize on lrck 0->1 (left slot end): count = DATA_W -> word stored in left holding register, left_ok = 1; else left_ok = 0 and frame_err pulses.
REQ-021 Finalize on lrck 1->0 (right slot end): count = DATA_W and left_ok = 1 -> l_data <= left holding, r_data <= shift word, valid pulses next clk; count < DATA_W -> frame_err pulses, outputs unchanged; left_ok cleared in both cases.
REQ-022 valid and frame_err SHALL be registered, high exactly one clk, and never high simultaneously.
REQ-023 Latency: valid rises on the second clk after the detect cycle that finalizes the right slot.
REQ-024 l_data/r_data SHALL hold their values between valid pulses.
REQ-025 sclk stopping mid-slot SHALL freeze state; no timeout.

Reset
REQ-026 reset low SHALL asynchronously clear synchronizers, shift register, count, holding register, left_ok, lrck_prev, l_data, r_data, valid, frame_err to 0 and force FSM to ALIGN.
REQ-027 reset asserted mid-slot SHALL discard the partial word; after release, the first pair output requires a full left+right frame after a fresh lrck 1->0.

Structure
REQ-028 Shared package SHALL hold DATA_W default, FSM state encodings (ALIGN, RECV), and SYNC_STAGES default, shared with the I2S transmitter.
REQ-029 One sub-module, sync_edge: parameterized synchronizer plus rising-edge detector, instanced for sclk; lrck and sdin use its synchronizer only.

Verification
REQ-030 Bench I2S master (sclk = clk/8, 24-bit slots) sends L=24'h123456, R=24'hABCDEF -> one valid pulse, l_data=24'h123456, r_data=24'hABCDEF.
REQ-031 32-bit slots, L=24'h800001 followed by 8 bits 8'hFF, R=24'h7FFFFE followed by 8'h00 -> l_data=24'h800001, r_data=24'h7FFFFE, no frame_err.
REQ-032 Stimulus starts mid-right-slot after reset -> no valid until a full frame after first lrck 1->0; first pair matches sent values.
REQ-033 Left slot of 16 bits then right of 24 -> frame_err on left end, no valid; outputs remain at previous values.
REQ-034 reset pulsed low mid-left-slot -> all outputs 0 immediately; next complete frame L=24'h000F0F, R=24'hF0F000 produces correct pair.
REQ-035 Ten back-to-back frames with incrementing samples -> exactly ten valid pulses, each pair correct, no frame_err.
